// File: rtl/vmm_job_arbiter.sv
// vmm_job_arbiter: round-robin owner of one VMM engine; start pulse, owner-only result routing, done pulse.
// Optional RUN-phase watchdog enabled by defining VMM_ARB_WATCHDOG_EN.
module vmm_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            vmm_clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  owner_o,
  output logic            busy_o,
  output logic            start_o,
  input  logic            eng_next_i,
  input  logic [DW-1:0]   eng_data_i,
  input  logic            eng_done_i,
  output logic [NREQ-1:0] res_valid_o,
  output logic [DW-1:0]   res_data_o,
  output logic [NREQ-1:0] done_o,
  output logic            err_o,
  output logic [1:0]      state_o
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d, last_q, last_d, pick, idx;
  logic [NREQ-1:0] res_valid_q, res_valid_d, own_oh;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            tmo, fwd;
  assign own_oh = NREQ'(1) << owner_q;
  assign fwd    = (state_q == RUN) && eng_next_i;
  // Descending scan so the requester closest after last_q is assigned last and wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (req_i[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    res_valid_d = fwd ? own_oh : '0;
    res_data_d  = fwd ? eng_data_i : res_data_q;
    case (state_q)
      IDLE: if (|req_i) begin
        owner_d = pick;
        state_d = START;
      end
      START: state_d = RUN;
      RUN: if (eng_done_i || tmo) state_d = DONE;
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
`ifdef VMM_ARB_WATCHDOG_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  // A timeout coinciding with eng_done_i counts as a normal completion.
  assign tmo   = (state_q == RUN) && (cnt_q + 16'd1 == 16'(TIMEOUT));
  assign cnt_d = (state_q == START) ? 16'd0 : (state_q == RUN) ? cnt_q + 16'd1 : cnt_q;
  assign err_d = (state_q == RUN) ? (tmo && !eng_done_i) : err_q;
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = (state_q == DONE) && err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif
  assign gnt_o       = (state_q != IDLE) ? own_oh : '0;
  assign done_o      = (state_q == DONE) ? own_oh : '0;
  assign busy_o      = state_q != IDLE;
  assign start_o     = state_q == START;
  assign owner_o     = owner_q;
  assign state_o     = state_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
endmodule

// File: tb/tb_vmm_job_arbiter.sv
// tb_vmm_job_arbiter: directed checks of grant order, result routing, done/reset behaviour and watchdog.
module tb_vmm_job_arbiter;
  logic       vmm_clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [1:0] req_i = '0;
  logic       eng_next_i = 1'b0;
  logic [7:0] eng_data_i = '0;
  logic       eng_done_i = 1'b0;
  logic [1:0] gnt_o, res_valid_o, done_o, state_o;
  logic [0:0] owner_o;
  logic       busy_o, start_o, err_o;
  logic [7:0] res_data_o;
  int n_run = 0, n_fail = 0;

  vmm_job_arbiter #(.NREQ(2), .IDW(1), .DW(8), .TIMEOUT(16)) dut (
    .vmm_clk(vmm_clk), .rst_(rst_), .req_i(req_i), .gnt_o(gnt_o), .owner_o(owner_o),
    .busy_o(busy_o), .start_o(start_o), .eng_next_i(eng_next_i), .eng_data_i(eng_data_i),
    .eng_done_i(eng_done_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 vmm_clk = ~vmm_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vmm_clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_data", 32'(res_data_o), 0);
    tick();
    rst_ = 1'b1;
    tick();
    chk("idle_stay", 32'(state_o), 0);
    // single request: one-cycle latency to START
    req_i = 2'b01;
    tick();
    chk("t1_state", 32'(state_o), 1);
    chk("t1_gnt", 32'(gnt_o), 2'b01);
    chk("t1_start", 32'(start_o), 1);
    chk("t1_busy", 32'(busy_o), 1);
    req_i = 2'b11;
    tick();
    chk("t1_run", 32'(state_o), 2);
    chk("t1_start_off", 32'(start_o), 0);
    chk("t1_gnt_held", 32'(gnt_o), 2'b01);
    eng_next_i = 1'b1; eng_data_i = 8'h55;
    tick();
    chk("o0_valid", 32'(res_valid_o), 2'b01);
    chk("o0_data", 32'(res_data_o), 8'h55);
    eng_next_i = 1'b0; eng_data_i = 8'hEE;
    tick();
    chk("o0_valid_off", 32'(res_valid_o), 0);
    chk("o0_data_hold", 32'(res_data_o), 8'h55);
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    chk("t4_state", 32'(state_o), 3);
    chk("t4_done", 32'(done_o), 2'b01);
    chk("t4_gnt", 32'(gnt_o), 2'b01);
    tick();
    chk("t4_idle", 32'(state_o), 0);
    chk("t4_gnt_off", 32'(gnt_o), 0);
    chk("t4_busy_off", 32'(busy_o), 0);
    chk("t4_done_off", 32'(done_o), 0);
    chk("t4_owner_kept", 32'(owner_o), 0);
    // both requesting: rotation hands engine to requester 1
    tick();
    chk("t2_gnt1", 32'(gnt_o), 2'b10);
    chk("t2_owner1", 32'(owner_o), 1);
    tick();
    eng_next_i = 1'b1; eng_data_i = 8'h2A;
    tick();
    chk("t3_valid", 32'(res_valid_o), 2'b10);
    chk("t3_data", 32'(res_data_o), 8'h2A);
    eng_data_i = 8'h3C; eng_done_i = 1'b1;
    tick();
    eng_next_i = 1'b0; eng_done_i = 1'b0;
    chk("same_state", 32'(state_o), 3);
    chk("same_valid", 32'(res_valid_o), 2'b10);
    chk("same_data", 32'(res_data_o), 8'h3C);
    chk("same_done", 32'(done_o), 2'b10);
    tick();
    chk("owner1_kept", 32'(owner_o), 1);
    tick();
    chk("t2_back0", 32'(gnt_o), 2'b01);
    tick();
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    tick();
    tick();
    chk("t5_pre_owner1", 32'(gnt_o), 2'b10);
    tick();
    eng_next_i = 1'b1; eng_data_i = 8'h77;
    tick();
    eng_next_i = 1'b0;
    chk("t5_pre_valid", 32'(res_valid_o), 2'b10);
    // asynchronous reset mid-RUN
    #2 rst_ = 1'b0;
    #1;
    chk("t5_state", 32'(state_o), 0);
    chk("t5_gnt", 32'(gnt_o), 0);
    chk("t5_valid", 32'(res_valid_o), 0);
    chk("t5_data", 32'(res_data_o), 0);
    chk("t5_owner", 32'(owner_o), 0);
    tick();
    rst_ = 1'b1;
    tick();
    chk("t5_prio0", 32'(gnt_o), 2'b01);
    req_i = 2'b00;
    tick();
`ifdef VMM_ARB_WATCHDOG_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("wd_run%0d", i), 32'(state_o), 2);
    end
    tick();
    chk("wd_state", 32'(state_o), 3);
    chk("wd_err", 32'(err_o), 1);
    chk("wd_done", 32'(done_o), 2'b01);
    tick();
    chk("wd_gnt_off", 32'(gnt_o), 0);
    chk("wd_err_off", 32'(err_o), 0);
`else
    for (int i = 1; i < 24; i++) begin
      tick();
      chk($sformatf("nowd_run%0d", i), 32'(state_o), 2);
      chk($sformatf("nowd_err%0d", i), 32'(err_o), 0);
    end
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    chk("nowd_done", 32'(done_o), 2'b01);
    chk("nowd_err_done", 32'(err_o), 0);
    tick();
    chk("nowd_idle", 32'(state_o), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
